// File: rtl/aud_mem_arbiter.sv
// Arbiter for the shared 16-bit x 256K audio sample RAM: stream engine (A) has priority,
// host (H) is forced through after STARVE_MAX A wins. Optional counters: AUD_ARB_STATS_EN.
module aud_mem_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLOCK_50,
  input  logic              AUDINF_RESET,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
`ifdef AUD_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_forced
`endif
);
  // Handshake: a transfer happens on the rising edge where x_req & x_gnt; the requester
  // holds its request fields stable until gnt and may present the next one the cycle after.
  localparam int         TAG_D      = RD_LAT + 1;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [TAG_D-1:0]  tag_valid_q, tag_valid_d;
  logic [TAG_D-1:0]  tag_owner_q, tag_owner_d;
  logic              a_rvalid_q, a_rvalid_d, h_rvalid_q, h_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, h_rdata_q, h_rdata_d;
  logic              force_h, a_xfer, h_xfer, rd_issue;

  assign force_h = a_req & h_req & (starve_q == STARVE_LIM);

  always_comb begin
    a_gnt = 1'b0;
    h_gnt = 1'b0;
    if (AUDINF_RESET) begin
      if (a_req && !force_h) a_gnt = 1'b1;
      else if (h_req)        h_gnt = 1'b1;
    end
  end

  assign a_xfer   = a_req & a_gnt;
  assign h_xfer   = h_req & h_gnt;
  assign rd_issue = (a_xfer & ~a_we) | (h_xfer & ~h_we);

  always_comb begin
    starve_d = starve_q;
    if (!h_req || h_xfer)                         starve_d = '0;
    else if (a_xfer && (starve_q < STARVE_LIM))   starve_d = starve_q + 8'd1;

    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (a_xfer) begin
      mem_addr_d  = a_addr;
      mem_wdata_d = a_wdata;
      mem_we_d    = a_we;
    end else if (h_xfer) begin
      mem_addr_d  = h_addr;
      mem_wdata_d = h_wdata;
      mem_we_d    = h_we;
    end

    // Owner bit 1 marks a host read; the last stage lines up with mem_q for that read.
    tag_valid_d = {tag_valid_q[TAG_D-2:0], rd_issue};
    tag_owner_d = {tag_owner_q[TAG_D-2:0], h_xfer};
    a_rvalid_d  = tag_valid_q[TAG_D-1] & ~tag_owner_q[TAG_D-1];
    h_rvalid_d  = tag_valid_q[TAG_D-1] &  tag_owner_q[TAG_D-1];
    a_rdata_d   = a_rvalid_d ? mem_q : a_rdata_q;
    h_rdata_d   = h_rvalid_d ? mem_q : h_rdata_q;
  end

  always_ff @(posedge CLOCK_50 or negedge AUDINF_RESET) begin
    if (!AUDINF_RESET) begin
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      tag_valid_q <= '0;
      tag_owner_q <= '0;
      a_rvalid_q  <= 1'b0;
      h_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      h_rdata_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
      a_rvalid_q  <= a_rvalid_d;
      h_rvalid_q  <= h_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      h_rdata_q   <= h_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign a_rvalid  = a_rvalid_q;
  assign h_rvalid  = h_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign h_rdata   = h_rdata_q;
  assign busy      = a_req | h_req | (|tag_valid_q);

`ifdef AUD_ARB_STATS_EN
  logic [15:0] conf_q, conf_d, forced_q, forced_d;

  always_comb begin
    conf_d   = conf_q;
    forced_d = forced_q;
    if (stat_clr) begin
      conf_d   = '0;
      forced_d = '0;
    end else begin
      if (a_req && h_req && (conf_q != 16'hFFFF)) conf_d   = conf_q + 16'd1;
      if (force_h && (forced_q != 16'hFFFF))      forced_d = forced_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge AUDINF_RESET) begin
    if (!AUDINF_RESET) begin
      conf_q   <= '0;
      forced_q <= '0;
    end else begin
      conf_q   <= conf_d;
      forced_q <= forced_d;
    end
  end

  assign stat_conflicts = conf_q;
  assign stat_forced    = forced_q;
`endif

endmodule

// File: doc/aud_mem_arbiter.md
Name: aud_mem_arbiter

Overview:
- Shares the single-port 16-bit x 256K audio sample RAM between two requesters.
- Requester A is the audio stream engine (playback reads, record writes). It has priority and a real-time deadline.
- Requester H is the host side (waveform display, sample upload/download).
- Issues at most one RAM access per CLOCK_50 cycle and returns tagged read data to the requester that issued it.

Parameters:
- ADDR_W, 18, RAM address width
- DATA_W, 16, sample width
- RD_LAT, 2, RAM read latency in cycles from registered mem_addr to valid mem_q (range 1..4)
- STARVE_MAX, 8, consecutive A grants tolerated while H waits before H is forced through (range 1..255)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- AUDINF_RESET  in  1  reset, asynchronous, active-low
- a_req  in  1  A request valid (level)
- a_we  in  1  A write (1) / read (0)
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A transfer accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid, one-cycle pulse
- a_rdata  out  DATA_W  A read data
- h_req, h_we, h_addr, h_wdata  in  1/1/ADDR_W/DATA_W  H request, same meaning as A
- h_gnt, h_rvalid, h_rdata  out  1/1/DATA_W  H grant/response, same meaning as A
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_q  in  DATA_W  RAM read data
- busy  out  1  any read in flight or any request pending

Behaviour:
- Reset (async, AUDINF_RESET=0):
  - mem_addr=0, mem_wdata=0, mem_we=0.
  - a_rvalid=h_rvalid=0; a_rdata=h_rdata=0.
  - Starvation counter=0, tag pipeline cleared.
  - Reads in flight are dropped; no rvalid is ever produced for them.
  - a_gnt and h_gnt are forced 0 while reset is asserted.
- Handshake: valid/ready. A transfer occurs on a rising edge where x_req & x_gnt. The requester holds req/we/addr/wdata stable until it sees gnt, and may present the next request in the following cycle (back-to-back allowed).
- Arbitration, evaluated combinationally each cycle:
  - Exactly one of a_gnt/h_gnt is 1 when any req is high; both are 0 when no req is high.
  - Only a_req high: grant A. Only h_req high: grant H.
  - Both high and starve counter < STARVE_MAX: grant A.
  - Both high and starve counter == STARVE_MAX: grant H.
- Starvation counter (8-bit):
  - Increments on each A transfer while h_req=1.
  - Clears on any H transfer, or on any cycle with h_req=0.
  - Saturates at STARVE_MAX; never wraps.
- Issue: on the transfer edge, mem_addr/mem_wdata/mem_we load from the winner. With no transfer, mem_we loads 0 and mem_addr holds its value.
- Tag pipeline: shift register RD_LAT+1 deep, fields {valid, owner}. It loads valid=1 on a read transfer; write transfers load valid=0.
- Read return:
  - If the transfer is at edge T, x_rvalid is high for exactly one cycle, starting at edge T+RD_LAT+1.
  - x_rdata captures mem_q on that edge and holds its value until the next x_rvalid.
- Read data returns in issue order. A and H reads interleave without loss, up to one per cycle.
- Write then read of the same address in consecutive transfers returns the new data. The RAM is write-first; the arbiter adds no forwarding.
- busy = a_req | h_req | any tag valid.

Optional Feature:
- Macro AUD_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_conflicts[15:0] (cycles with a_req & h_req both high) and stat_forced[15:0] (H grants caused by starvation).
  - Both counters saturate at 16'hFFFF and reset to 0.
  - Input stat_clr (sync, active-high) zeroes both counters; stat_clr takes priority over a same-cycle increment.
- Undefined: no counters, no stat ports.

Test Plan:
- Reset with no requests -> all outputs 0, busy=0. A reads addr 0x00010 at cycle 5 -> a_gnt=1 at cycle 5, mem_addr=0x00010 from cycle 6, a_rvalid pulse at cycle 8 (RD_LAT=2), a_rdata=RAM[0x10].
- a_req and h_req held high continuously, STARVE_MAX=8 -> pattern of 8 A grants then 1 H grant, repeated; h_gnt never stays low for more than 8 consecutive cycles.
- Interleaved A reads of 0x100 and 0x101, then H read of 0x200, on consecutive cycles -> a_rvalid, a_rvalid, h_rvalid on 3 consecutive cycles with correct data; the A and H data paths are never crossed.
- H write 0x1234 to 0x3FFFF, then A read of 0x3FFFF on the next cycle -> a_rdata=0x1234. mem_we is high for exactly 1 cycle.
- Two A reads in flight, AUDINF_RESET pulsed low mid-latency -> no a_rvalid after reset release; mem_we=0; starve counter restarts at 0.
- AUD_ARB_STATS_EN defined, 10 cycles of dual requests -> stat_conflicts=10, stat_forced=1. stat_clr asserted -> both counters 0 the next cycle.
